ysyx_22041207_if_prefetch: RTL and testbench

//  Parametrised instruction-fetch unit with a prefetch queue. Issues sequential reads on the
//  rx_* read channel and unpacks each 64-bit beat into one or two 32-bit instructions. Buffers

---
 rtl/ysyx_22041207_pkg.sv | 45 ++++
 rtl/ysyx_22041207_fetch_fifo.sv | 73 +++++++
 rtl/ysyx_22041207_if_prefetch.sv | 174 +++++++++++++++++
 tb/tb_ysyx_22041207_if_prefetch.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_pkg.sv
// Shared definitions for the instruction-fetch slice: reset PC, bus size code,
// fetch FSM encoding and the instruction-queue entry layout.
package ysyx_22041207_pkg;

    // Default fetch address after reset
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // Read-size code for one full 8-byte beat
    localparam logic [7:0] RX_SIZE_8B = 8'b0000_1111;

    // Bytes delivered per read beat
    localparam logic [63:0] LINE_BYTES = 64'd8;

    // Fetch bus sequencer: at most one request in flight
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_e;

    // One queue entry: 32-bit instruction, its PC and the misaligned-target marker
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        misalign;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Round a PC down to the start of its 8-byte beat
    function automatic logic [63:0] align8(input logic [63:0] pc);
        return pc & ~64'h7;
    endfunction

    // Start of the beat following the one holding pc; wraps modulo 2^64
    function automatic logic [63:0] next_line(input logic [63:0] pc);
        return align8(pc) + LINE_BYTES;
    endfunction

    // Instruction fetch requires a 4-byte aligned target
    function automatic logic is_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041207_fetch_fifo.sv
// Instruction queue: synchronous FIFO of fetch entries that can accept two
// entries per cycle (both halves of one beat) and release one per cycle.
// Flush empties it and overrides any push issued in the same cycle.
module ysyx_22041207_fetch_fifo
    import ysyx_22041207_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push0,
    input  fetch_entry_t             push0_data,
    input  logic                     push1,
    input  fetch_entry_t             push1_data,
    input  logic                     pop,
    output logic                     head_valid,
    output fetch_entry_t             head_data,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_next_slot;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;
    logic             do_pop;
    logic             do_push0;
    logic             do_push1;

    // Work out how many entries enter and leave this cycle; push1 rides on push0
    always_comb begin
        do_pop           = pop && (count != '0);
        do_push0         = push0 && !flush;
        do_push1         = push0 && push1 && !flush;
        push_n           = do_push1 ? CNT_W'(2) : (do_push0 ? CNT_W'(1) : '0);
        pop_n            = do_pop ? CNT_W'(1) : '0;
        wr_ptr_next_slot = wr_ptr + PTR_W'(1);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            count  <= count + push_n - pop_n;
        end
    end

    // Storage write; the second entry of a beat lands in the slot after the first
    always_ff @(posedge clk) begin
        if (do_push0) begin
            mem[wr_ptr] <= push0_data;
        end
        if (do_push1) begin
            mem[wr_ptr_next_slot] <= push1_data;
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign free_cnt   = CNT_W'(DEPTH) - count;

endmodule

// File: rtl/ysyx_22041207_if_prefetch.sv
// Instruction fetch with prefetch queue: issues one sequential 8-byte read at a
// time, splits each beat into 32-bit instructions, queues them for decode and
// handles redirects by flushing the queue and discarding the in-flight beat.
module ysyx_22041207_if_prefetch
    import ysyx_22041207_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4,
    parameter int          BUS_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_o,
    output logic [63:0]      pc_o,
    output logic             inst_misalign,
    output logic             rx_r_valid_i,
    input  logic             rx_r_ready_o,
    output logic [63:0]      rx_r_addr_i,
    output logic [7:0]       rx_r_size_i,
    input  logic             rx_data_valid,
    input  logic [BUS_W-1:0] rx_data_read_o,
    output logic             rx_data_ready
);

    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic [63:0]       fetch_pc;
    logic              drop;
    logic              halt;
    logic              marker_pending;
    logic              redirect_misaligned;

    logic              issue;
    logic              beat_fire;
    logic              beat_push;

    logic              push0;
    logic              push1;
    fetch_entry_t      push0_data;
    fetch_entry_t      push1_data;
    logic              pop;
    logic              head_valid;
    fetch_entry_t      head_data;
    logic [FREE_W-1:0] free_cnt;

    assign redirect_misaligned = is_misaligned(redirect_pc);

    // Bus sequencer: a new request only when not halted, not being redirected,
    // and the queue can absorb a full two-instruction beat
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        beat_fire  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!redirect_valid && !halt && (free_cnt >= FREE_W'(2))) begin
                    issue      = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_r_ready_o) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_data_valid) begin
                    beat_fire  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request address is captured at issue and held until the slave takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_r_addr_i <= '0;
        end else if (issue) begin
            rx_r_addr_i <= align8(fetch_pc);
        end
    end

    assign rx_r_valid_i  = (state == ST_ADDR);
    assign rx_data_ready = (state == ST_DATA);
    assign rx_r_size_i   = RX_SIZE_8B;

    // Build queue writes: a misaligned-target marker, or the usable half(s) of a fresh beat
    always_comb begin
        beat_push  = beat_fire && !drop && !redirect_valid;
        push0      = 1'b0;
        push1      = 1'b0;
        push0_data = '0;
        push1_data = '0;
        if (marker_pending) begin
            push0      = 1'b1;
            push0_data = {32'h0, fetch_pc, 1'b1};
        end else if (beat_push) begin
            push0 = 1'b1;
            if (!fetch_pc[2]) begin
                push0_data = {rx_data_read_o[31:0], fetch_pc, 1'b0};
                push1      = 1'b1;
                push1_data = {rx_data_read_o[63:32], fetch_pc + 64'd4, 1'b0};
            end else begin
                push0_data = {rx_data_read_o[63:32], fetch_pc, 1'b0};
            end
        end
    end

    // Fetch PC, stale-beat drop flag and misalignment halt; redirect overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            drop           <= 1'b0;
            halt           <= 1'b0;
            marker_pending <= 1'b0;
        end else begin
            marker_pending <= 1'b0;
            if (redirect_valid) begin
                fetch_pc       <= redirect_pc;
                halt           <= redirect_misaligned;
                marker_pending <= redirect_misaligned;
                drop           <= (state == ST_ADDR) || ((state == ST_DATA) && !beat_fire);
            end else if (beat_fire) begin
                drop <= 1'b0;
                if (!drop) begin
                    fetch_pc <= next_line(fetch_pc);
                end
            end
        end
    end

    assign pop = head_valid && inst_ready;

    ysyx_22041207_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push0      (push0),
        .push0_data (push0_data),
        .push1      (push1),
        .push1_data (push1_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .free_cnt   (free_cnt)
    );

    assign inst_valid    = head_valid;
    assign inst_o        = head_valid ? head_data.inst : 32'h0;
    assign pc_o          = head_valid ? head_data.pc : 64'h0;
    assign inst_misalign = head_valid && head_data.misalign;

endmodule

// File: tb/tb_ysyx_22041207_if_prefetch.sv
// Directed bench for the fetch unit: a small read slave with programmable
// address/data latency, a monitor logging decode pops and bus requests, and
// hand-computed expectations for reset, streaming, stalls and redirects.
module tb_ysyx_22041207_if_prefetch;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        mis;
    } pop_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        inst_misalign;
    logic        rx_r_valid_i;
    logic        rx_r_ready_o;
    logic [63:0] rx_r_addr_i;
    logic [7:0]  rx_r_size_i;
    logic        rx_data_valid;
    logic [63:0] rx_data_read_o;
    logic        rx_data_ready;

    int checks = 0;
    int errors = 0;

    int addr_delay = 0;
    int data_delay = 0;
    int a_cnt = 0;
    int d_cnt = 0;
    logic        d_pend = 1'b0;
    logic [63:0] d_addr = 64'h0;

    pop_t        popped[$];
    logic [63:0] addr_q[$];
    pop_t        monEntry;

    ysyx_22041207_if_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .inst_misalign  (inst_misalign),
        .rx_r_valid_i   (rx_r_valid_i),
        .rx_r_ready_o   (rx_r_ready_o),
        .rx_r_addr_i    (rx_r_addr_i),
        .rx_r_size_i    (rx_r_size_i),
        .rx_data_valid  (rx_data_valid),
        .rx_data_read_o (rx_data_read_o),
        .rx_data_ready  (rx_data_ready)
    );

    always #5 clk = ~clk;

    // Memory image: the two words at the reset vector are fixed, the rest derive from the address
    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0010_0113;
        if (a == 64'h8000_0004) return 32'h0000_0093;
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    assign rx_r_ready_o   = rx_r_valid_i && (a_cnt >= addr_delay);
    assign rx_data_valid  = d_pend && (d_cnt >= data_delay);
    assign rx_data_read_o = {memWord(d_addr + 64'd4), memWord(d_addr)};

    // Read slave: counts address-wait and data-wait cycles, serves one beat per request
    always @(posedge clk) begin
        if (rst) begin
            a_cnt  <= 0;
            d_cnt  <= 0;
            d_pend <= 1'b0;
        end else begin
            if (d_pend) begin
                if (rx_data_valid && rx_data_ready) d_pend <= 1'b0;
                else d_cnt <= d_cnt + 1;
            end
            if (rx_r_valid_i && rx_r_ready_o) begin
                a_cnt  <= 0;
                d_pend <= 1'b1;
                d_cnt  <= 0;
                d_addr <= rx_r_addr_i;
            end else if (rx_r_valid_i) begin
                a_cnt <= a_cnt + 1;
            end
        end
    end

    // Monitor on the falling edge: log every decode pop and every accepted read request
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            monEntry.inst = inst_o;
            monEntry.pc   = pc_o;
            monEntry.mis  = inst_misalign;
            popped.push_back(monEntry);
        end
        if (!rst && rx_r_valid_i && rx_r_ready_o) begin
            addr_q.push_back(rx_r_addr_i);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle redirect pulse
    task automatic applyStimulus(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic doReset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        inst_ready     = 1'b0;
        addr_delay     = 0;
        data_delay     = 0;
        tick(3);
        popped.delete();
        addr_q.delete();
        rst = 1'b0;
    endtask

    task automatic waitPopped(input int n, input int budget, input string tag);
        int k = 0;
        while (popped.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput(tag, 64'(popped.size() >= n), 64'd1);
    endtask

    task automatic waitAddr(input int n, input int budget, input string tag);
        int k = 0;
        while (addr_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput(tag, 64'(addr_q.size() >= n), 64'd1);
    endtask

    task automatic waitDataReady(input int budget, input string tag);
        int k = 0;
        while (!rx_data_ready && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput(tag, 64'(rx_data_ready), 64'd1);
    endtask

    function automatic pop_t getPop(input int i);
        pop_t e;
        e.inst = 32'h0;
        e.pc   = 64'h0;
        e.mis  = 1'b0;
        if (i < popped.size()) e = popped[i];
        return e;
    endfunction

    function automatic logic [63:0] getAddr(input int i);
        if (i < addr_q.size()) return addr_q[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
        checkOutput({tag, "_inst_o"}, 64'(inst_o), 64'd0);
        checkOutput({tag, "_pc_o"}, pc_o, 64'd0);
        checkOutput({tag, "_misalign"}, 64'(inst_misalign), 64'd0);
        checkOutput({tag, "_r_valid"}, 64'(rx_r_valid_i), 64'd0);
        checkOutput({tag, "_r_addr"}, rx_r_addr_i, 64'd0);
        checkOutput({tag, "_data_ready"}, 64'(rx_data_ready), 64'd0);
    endtask

    initial begin
        pop_t e;

        // T1: reset values, then the first beat is split low-word first
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        inst_ready     = 1'b0;
        tick(3);
        checkResetOutputs("t1_rst");
        checkOutput("t1_size", 64'(rx_r_size_i), 64'h0F);
        rst        = 1'b0;
        inst_ready = 1'b1;
        waitPopped(2, 50, "t1_wait_pop");
        waitAddr(2, 50, "t1_wait_addr");
        e = getPop(0);
        checkOutput("t1_pop0_pc", e.pc, 64'h8000_0000);
        checkOutput("t1_pop0_inst", 64'(e.inst), 64'h0010_0113);
        e = getPop(1);
        checkOutput("t1_pop1_pc", e.pc, 64'h8000_0004);
        checkOutput("t1_pop1_inst", 64'(e.inst), 64'h0000_0093);
        checkOutput("t1_addr0", getAddr(0), 64'h8000_0000);
        checkOutput("t1_addr1", getAddr(1), 64'h8000_0008);

        // T2: decode stalled -> queue fills to four, fetch pauses, then drains in order
        doReset();
        tick(20);
        checkOutput("t2_req_count", 64'(addr_q.size()), 64'd2);
        checkOutput("t2_inst_valid", 64'(inst_valid), 64'd1);
        checkOutput("t2_no_req", 64'(rx_r_valid_i), 64'd0);
        checkOutput("t2_head_pc", pc_o, 64'h8000_0000);
        inst_ready = 1'b1;
        waitPopped(8, 100, "t2_wait_pop");
        for (int i = 0; i < 8; i++) begin
            e = getPop(i);
            checkOutput($sformatf("t2_pc%0d", i), e.pc, 64'h8000_0000 + 64'(4 * i));
            checkOutput($sformatf("t2_inst%0d", i), 64'(e.inst), 64'(memWord(64'h8000_0000 + 64'(4 * i))));
        end

        // T3: redirect while waiting for data -> stale beat dropped, upper word of the target beat only
        doReset();
        inst_ready = 1'b1;
        data_delay = 5;
        waitDataReady(20, "t3_wait_data");
        applyStimulus(64'h8000_0104);
        waitPopped(2, 200, "t3_wait_pop");
        waitAddr(3, 200, "t3_wait_addr");
        checkOutput("t3_addr0", getAddr(0), 64'h8000_0000);
        checkOutput("t3_addr1", getAddr(1), 64'h8000_0100);
        checkOutput("t3_addr2", getAddr(2), 64'h8000_0108);
        e = getPop(0);
        checkOutput("t3_pop0_pc", e.pc, 64'h8000_0104);
        checkOutput("t3_pop0_inst", 64'(e.inst), 64'(memWord(64'h8000_0104)));
        checkOutput("t3_pop0_mis", 64'(e.mis), 64'd0);
        e = getPop(1);
        checkOutput("t3_pop1_pc", e.pc, 64'h8000_0108);

        // T4: redirect during a slow address phase -> request held stable until accepted
        doReset();
        inst_ready = 1'b1;
        addr_delay = 5;
        begin
            int k = 0;
            while (!rx_r_valid_i && k < 20) begin
                tick(1);
                k++;
            end
        end
        checkOutput("t4_wait_valid", 64'(rx_r_valid_i), 64'd1);
        applyStimulus(64'h8000_0300);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t4_hold_valid%0d", i), 64'(rx_r_valid_i), 64'd1);
            checkOutput($sformatf("t4_hold_addr%0d", i), rx_r_addr_i, 64'h8000_0000);
            tick(1);
        end
        waitPopped(1, 200, "t4_wait_pop");
        waitAddr(2, 200, "t4_wait_addr");
        checkOutput("t4_addr0", getAddr(0), 64'h8000_0000);
        checkOutput("t4_addr1", getAddr(1), 64'h8000_0300);
        e = getPop(0);
        checkOutput("t4_pop0_pc", e.pc, 64'h8000_0300);
        checkOutput("t4_pop0_inst", 64'(e.inst), 64'(memWord(64'h8000_0300)));

        // T5: misaligned redirect -> one marker, fetch halted until the next redirect
        doReset();
        applyStimulus(64'h8000_0102);
        tick(2);
        checkOutput("t5_mark_valid", 64'(inst_valid), 64'd1);
        checkOutput("t5_mark_inst", 64'(inst_o), 64'd0);
        checkOutput("t5_mark_pc", pc_o, 64'h8000_0102);
        checkOutput("t5_mark_mis", 64'(inst_misalign), 64'd1);
        inst_ready = 1'b1;
        tick(20);
        checkOutput("t5_halt_reqs", 64'(addr_q.size()), 64'd0);
        checkOutput("t5_halt_pops", 64'(popped.size()), 64'd1);
        checkOutput("t5_halt_valid", 64'(inst_valid), 64'd0);
        applyStimulus(64'h8000_0200);
        waitPopped(3, 100, "t5_wait_pop");
        checkOutput("t5_addr0", getAddr(0), 64'h8000_0200);
        e = getPop(1);
        checkOutput("t5_pop1_pc", e.pc, 64'h8000_0200);
        checkOutput("t5_pop1_mis", 64'(e.mis), 64'd0);
        checkOutput("t5_pop1_inst", 64'(e.inst), 64'(memWord(64'h8000_0200)));

        // T6: reset with entries queued and a beat outstanding
        doReset();
        begin
            int k = 0;
            while (!inst_valid && k < 20) begin
                tick(1);
                k++;
            end
        end
        checkOutput("t6_wait_valid", 64'(inst_valid), 64'd1);
        data_delay = 10;
        waitDataReady(20, "t6_wait_data");
        rst = 1'b1;
        tick(1);
        checkResetOutputs("t6_rst");
        data_delay = 0;
        popped.delete();
        addr_q.delete();
        rst        = 1'b0;
        inst_ready = 1'b1;
        waitPopped(1, 50, "t6_wait_pop");
        checkOutput("t6_addr0", getAddr(0), 64'h8000_0000);
        e = getPop(0);
        checkOutput("t6_pop0_pc", e.pc, 64'h8000_0000);
        checkOutput("t6_pop0_inst", 64'(e.inst), 64'h0010_0113);

        // T7: fetch address wraps past the top of the address space
        doReset();
        inst_ready = 1'b1;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFC);
        waitPopped(2, 100, "t7_wait_pop");
        waitAddr(2, 100, "t7_wait_addr");
        checkOutput("t7_addr0", getAddr(0), 64'hFFFF_FFFF_FFFF_FFF8);
        checkOutput("t7_addr1", getAddr(1), 64'h0);
        e = getPop(0);
        checkOutput("t7_pop0_pc", e.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("t7_pop0_inst", 64'(e.inst), 64'(memWord(64'hFFFF_FFFF_FFFF_FFFC)));
        e = getPop(1);
        checkOutput("t7_pop1_pc", e.pc, 64'h0);
        checkOutput("t7_pop1_inst", 64'(e.inst), 64'(memWord(64'h0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
